// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM receive path.
package tdm_pkg;

    localparam int TDM_NUM_LANES = 4;

    typedef enum logic {
        TDM_IDLE,
        TDM_COLLECT
    } tdm_state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// Wrapping slot index: load-to-1 on start of frame, increment per sample, else hold.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int NUM_LANES = TDM_NUM_LANES,
    parameter int SEL_W     = $clog2(NUM_LANES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             inc,
    output logic [SEL_W-1:0] slot,
    output logic             last
);

    logic [SEL_W-1:0] slot_q;
    logic [SEL_W-1:0] slot_d;

    always_comb begin
        slot_d = slot_q;
        if (load) begin
            slot_d = SEL_W'(1);
        end else if (inc) begin
            slot_d = slot_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot = slot_q;
    assign last = (slot_q == SEL_W'(NUM_LANES - 1));

endmodule

// File: rtl/tdm_demux4.sv
// TDM serial-to-parallel receiver: frames on sof, presents each completed frame as a registered word.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int NUM_LANES = TDM_NUM_LANES,
    parameter int SEL_W     = $clog2(NUM_LANES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din,
    input  logic                 din_valid,
    input  logic                 sof,
    output logic [NUM_LANES-1:0] out,
    output logic                 out_valid,
    output logic [SEL_W-1:0]     slot,
    output logic                 frame_err
);

    tdm_state_e           state_q, state_d;
    logic [NUM_LANES-1:0] collect_q, collect_d;
    logic [NUM_LANES-1:0] out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 frame_err_q, frame_err_d;

    logic                 cnt_load;
    logic                 cnt_inc;
    logic [SEL_W-1:0]     slot_cur;
    logic                 slot_last;

    tdm_slot_counter #(
        .NUM_LANES (NUM_LANES),
        .SEL_W     (SEL_W)
    ) u_slot_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .inc   (cnt_inc),
        .slot  (slot_cur),
        .last  (slot_last)
    );

    always_comb begin
        state_d     = state_q;
        collect_d   = collect_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;
        cnt_load    = 1'b0;
        cnt_inc     = 1'b0;

        if (din_valid) begin
            case (state_q)
                TDM_IDLE: begin
                    if (sof) begin
                        collect_d[0] = din;
                        cnt_load     = 1'b1;
                        state_d      = TDM_COLLECT;
                    end
                end
                TDM_COLLECT: begin
                    if (sof) begin
                        // sof mid-frame drops the partial word; at slot 0 it is a clean restart
                        collect_d[0] = din;
                        cnt_load     = 1'b1;
                        frame_err_d  = (slot_cur != '0);
                    end else begin
                        collect_d[slot_cur] = din;
                        cnt_inc             = 1'b1;
                        if (slot_last) begin
                            out_d       = collect_d;
                            out_valid_d = 1'b1;
                        end
                    end
                end
                default: state_d = TDM_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= TDM_IDLE;
            collect_q   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            collect_q   <= collect_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign slot      = slot_cur;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: directed frames, gaps, sof errors and async reset.
module tb_tdm_demux4;

    localparam int NL = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          din = 1'b0;
    logic          din_valid = 1'b0;
    logic          sof = 1'b0;
    logic [NL-1:0] out;
    logic          out_valid;
    logic [SW-1:0] slot;
    logic          frame_err;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    bit done = 1'b0;

    typedef struct {
        logic [NL-1:0] word;
        int            at_cyc;
    } exp_word_t;

    exp_word_t exp_q[$];
    int        err_q[$];

    tdm_demux4 #(.NUM_LANES(NL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .sof       (sof),
        .out       (out),
        .out_valid (out_valid),
        .slot      (slot),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: pops expectations whenever the DUT presents a frame or an error pulse.
    always @(negedge clk) begin
        if (!done) begin
            if (out_valid && frame_err)
                check("valid_err_coincident", 1, 0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", int'(out), -1);
                end else begin
                    exp_word_t e;
                    e = exp_q.pop_front();
                    check("out_word", int'(out), int'(e.word));
                    check("out_valid_cycle", cyc, e.at_cyc);
                end
            end
            if (frame_err) begin
                if (err_q.size() == 0) begin
                    check("unexpected_frame_err", cyc, -1);
                end else begin
                    int ec;
                    ec = err_q.pop_front();
                    check("frame_err_cycle", cyc, ec);
                end
            end
        end
    end

    // Drive one accepted sample across the next rising edge, then check slot.
    task automatic send(input logic b, input logic s, input int exp_slot);
        din_valid = 1'b1;
        din       = b;
        sof       = s;
        @(posedge clk);
        #1;
        check("slot", int'(slot), exp_slot);
        @(negedge clk);
    endtask

    task automatic push_word(input logic [NL-1:0] w);
        exp_word_t e;
        e.word   = w;
        e.at_cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Gap cycles with junk on din/sof, which must be ignored.
    task automatic gap(input int n, input int exp_slot);
        for (int i = 0; i < n; i++) begin
            din_valid = 1'b0;
            din       = 1'b1;
            sof       = 1'b1;
            @(posedge clk);
            #1;
            check("slot_gap", int'(slot), exp_slot);
            @(negedge clk);
        end
        sof = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("rst_out", int'(out), 0);
        check("rst_slot", int'(slot), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_err", int'(frame_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        #1;
        check("reset_out", int'(out), 0);
        check("reset_slot", int'(slot), 0);
        check("reset_valid", int'(out_valid), 0);
        check("reset_err", int'(frame_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame: bits 0,1,0,1 -> 4'b1010
        send(1'b0, 1'b1, 1);
        send(1'b1, 1'b0, 2);
        send(1'b0, 1'b0, 3);
        push_word(4'b1010);
        send(1'b1, 1'b0, 0);
        gap(2, 0);
        check("out_hold", int'(out), 4'b1010);

        // Samples without sof in IDLE are dropped
        pulse_reset();
        send(1'b1, 1'b0, 0);
        send(1'b1, 1'b0, 0);
        send(1'b1, 1'b1, 1);
        send(1'b0, 1'b0, 2);
        send(1'b0, 1'b0, 3);
        push_word(4'b0001);
        send(1'b0, 1'b0, 0);
        gap(1, 0);

        // Back-to-back frames, sof only on the first
        pulse_reset();
        send(1'b1, 1'b1, 1);
        send(1'b0, 1'b0, 2);
        send(1'b1, 1'b0, 3);
        push_word(4'b0101);
        send(1'b0, 1'b0, 0);
        send(1'b0, 1'b0, 1);
        send(1'b1, 1'b0, 2);
        send(1'b1, 1'b0, 3);
        push_word(4'b0110);
        send(1'b0, 1'b0, 0);
        gap(1, 0);

        // sof mid-frame: error, partial frame discarded
        pulse_reset();
        send(1'b0, 1'b1, 1);
        send(1'b0, 1'b0, 2);
        err_q.push_back(cyc + 1);
        send(1'b1, 1'b1, 1);
        check("out_after_err", int'(out), 0);
        send(1'b1, 1'b0, 2);
        send(1'b1, 1'b0, 3);
        push_word(4'b1111);
        send(1'b1, 1'b0, 0);
        gap(1, 0);

        // Gaps between every sample
        send(1'b1, 1'b1, 1);
        gap(3, 1);
        send(1'b0, 1'b0, 2);
        gap(3, 2);
        send(1'b1, 1'b0, 3);
        gap(3, 3);
        push_word(4'b1101);
        send(1'b1, 1'b0, 0);
        gap(3, 0);
        check("out_gap_frame", int'(out), 4'b1101);

        // Async reset mid-frame, then a clean frame
        send(1'b1, 1'b1, 1);
        send(1'b1, 1'b0, 2);
        send(1'b1, 1'b0, 3);
        pulse_reset();
        send(1'b0, 1'b1, 1);
        send(1'b0, 1'b0, 2);
        send(1'b1, 1'b0, 3);
        push_word(4'b1100);
        send(1'b1, 1'b0, 0);
        gap(4, 0);

        check("pending_words", exp_q.size(), 0);
        check("pending_errs", err_q.size(), 0);
        done = 1'b1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
